// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO bundle: push side from the UART receiver, pop side and status to the consumer.
interface uart_rx_fifo_if #(
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter int unsigned DATA_W     = 8
);
   logic                  flush;
   logic                  wr_valid;
   logic [DATA_W-1:0]     wr_data;
   logic                  wr_err;
   logic                  rd_req;
   logic                  ovf_clr;
   logic                  rd_valid;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_err;
   logic                  empty;
   logic                  full;
   logic                  almost_full;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;

   modport master (
      output flush, wr_valid, wr_data, wr_err, rd_req, ovf_clr,
      input  rd_valid, rd_data, rd_err, empty, full, almost_full, level, overflow
   );

   modport slave (
      input  flush, wr_valid, wr_data, wr_err, rd_req, ovf_clr,
      output rd_valid, rd_data, rd_err, empty, full, almost_full, level, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO: stores {err, data} per rx_valid pulse, registered pop,
// level/status flags and a sticky overflow flag.
module uart_rx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned AF_LEVEL   = 6
) (
   input logic           clk,
   input logic           rst,
   uart_rx_fifo_if.slave bus
);
   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   lvl_t;

   localparam lvl_t FullLvl = lvl_t'(Depth);
   localparam lvl_t AfLvl   = lvl_t'(AF_LEVEL);

   logic [DATA_W:0]   mem_q [Depth];

   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   lvl_t              level_q, level_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_err_q, rd_err_d;
   logic              overflow_q, overflow_d;

   logic              empty_s, full_s, push, pop, drop;

   always_comb begin
      empty_s = (level_q == '0);
      full_s  = (level_q == FullLvl);
      // A pop frees a slot in the same cycle, so a push into a full FIFO with rd_req is kept.
      push    = bus.wr_valid && (!full_s || bus.rd_req) && !bus.flush;
      pop     = bus.rd_req && !empty_s && !bus.flush;
      drop    = bus.wr_valid && full_s && !bus.rd_req && !bus.flush;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      overflow_d = overflow_q;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_d                = rd_ptr_q + ptr_t'(1);
            rd_valid_d              = 1'b1;
            {rd_err_d, rd_data_d}   = mem_q[rd_ptr_q];
         end
         case ({push, pop})
            2'b10:   level_d = level_q + lvl_t'(1);
            2'b01:   level_d = level_q - lvl_t'(1);
            default: level_d = level_q;
         endcase
      end

      // A fresh drop beats a simultaneous clear.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; only entries below level are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.wr_err, bus.wr_data};
      end
   end

   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_err      = rd_err_q;
   assign bus.level       = level_q;
   assign bus.empty       = empty_s;
   assign bus.full        = full_s;
   assign bus.almost_full = (level_q >= AfLvl);
   assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: driver queues expected pops, negedge monitor checks them.
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DEPTH_LOG2(3), .DATA_W(8)) bus ();

   uart_rx_fifo #(.DEPTH_LOG2(3), .DATA_W(8), .AF_LEVEL(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] sb[$];
   int         mlevel  = 0;
   logic       mov     = 1'b0;
   logic       exp_rv  = 1'b0;
   logic [8:0] exp_hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_status();
      chk("level", 32'(bus.level), 32'(mlevel));
      chk("empty", 32'(bus.empty), 32'(mlevel == 0));
      chk("full", 32'(bus.full), 32'(mlevel == 8));
      chk("almost_full", 32'(bus.almost_full), 32'(mlevel >= 6));
      chk("overflow", 32'(bus.overflow), 32'(mov));
   endtask

   // One clock cycle of stimulus; inputs change just after the negedge.
   task automatic step(input logic wv, input logic [7:0] wd, input logic we, input logic rr,
                       input logic fl, input logic clr);
      logic full_m, push_ok, pop_ok;
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.wr_err   = we;
      bus.rd_req   = rr;
      bus.flush    = fl;
      bus.ovf_clr  = clr;
      full_m  = (mlevel == 8);
      push_ok = wv && (!full_m || rr) && !fl;
      pop_ok  = rr && (mlevel != 0) && !fl;
      if (fl) begin
         sb.delete();
         mlevel = 0;
      end else begin
         if (push_ok) sb.push_back({we, wd});
         if (push_ok && !pop_ok) mlevel++;
         else if (pop_ok && !push_ok) mlevel--;
      end
      if (wv && full_m && !rr && !fl) mov = 1'b1;
      else if (clr) mov = 1'b0;
      @(posedge clk);
      #1;
      exp_rv       = pop_ok;
      bus.wr_valid = 1'b0;
      bus.rd_req   = 1'b0;
      bus.flush    = 1'b0;
      bus.ovf_clr  = 1'b0;
      bus.wr_err   = 1'b0;
      check_status();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_hold = '0;
      end else begin
         chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
         if (bus.rd_valid) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_extra: got rd_valid with data 0x%0h expected no pop", bus.rd_data);
            end else begin
               exp_hold = sb.pop_front();
            end
            chk("rd_word", 32'({bus.rd_err, bus.rd_data}), 32'(exp_hold));
         end else begin
            chk("rd_hold", 32'({bus.rd_err, bus.rd_data}), 32'(exp_hold));
         end
      end
   end

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.wr_err   = 1'b0;
      bus.rd_req   = 1'b0;
      bus.flush    = 1'b0;
      bus.ovf_clr  = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check_status();
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_data", 32'({bus.rd_err, bus.rd_data}), 32'd0);
      rst = 1'b0;

      // In-order delivery with one-cycle latency
      step(1, 8'h41, 0, 0, 0, 0);
      step(1, 8'h42, 0, 0, 0, 0);
      step(1, 8'h43, 0, 0, 0, 0);
      chk("t1_level", 32'(bus.level), 32'd3);
      repeat (3) step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0);
      chk("t1_empty", 32'(bus.empty), 32'd1);

      // Fill, overflow drop, drain, clear
      for (int i = 0; i < 8; i++) begin
         step(1, 8'(i), 0, 0, 0, 0);
         if (i == 4) chk("t2_af_at5", 32'(bus.almost_full), 32'd0);
         if (i == 5) chk("t2_af_at6", 32'(bus.almost_full), 32'd1);
      end
      chk("t2_full", 32'(bus.full), 32'd1);
      step(1, 8'hFF, 0, 0, 0, 0);
      chk("t2_ovf", 32'(bus.overflow), 32'd1);
      chk("t2_level", 32'(bus.level), 32'd8);
      repeat (8) step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0, 0);
      chk("t2_ovf_kept", 32'(bus.overflow), 32'd1);
      step(0, 8'h00, 0, 0, 0, 1);
      chk("t2_ovf_clr", 32'(bus.overflow), 32'd0);

      // Push and pop together while full
      for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0, 0, 0);
      step(1, 8'h5A, 0, 1, 0, 0);
      chk("t3_level", 32'(bus.level), 32'd8);
      chk("t3_ovf", 32'(bus.overflow), 32'd0);
      repeat (8) step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0);

      // Push and pop together while empty: no bypass
      step(1, 8'h33, 0, 1, 0, 0);
      chk("t4_level", 32'(bus.level), 32'd1);
      step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0);

      // Per-entry error flag
      step(1, 8'h10, 1, 0, 0, 0);
      step(1, 8'h11, 0, 0, 0, 0);
      step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0);

      // Streaming with a flush in the middle
      step(1, 8'h80, 0, 0, 0, 0);
      for (int i = 1; i < 12; i++) begin
         step(1, 8'(8'h80 + i), 0, 1, (i == 6), 0);
         if (i == 6) begin
            chk("t6_flush_level", 32'(bus.level), 32'd0);
            chk("t6_flush_empty", 32'(bus.empty), 32'd1);
         end
      end
      step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a push
      step(1, 8'h21, 0, 0, 0, 0);
      step(1, 8'h22, 0, 0, 0, 0);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h99;
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      mlevel = 0;
      mov    = 1'b0;
      exp_rv = 1'b0;
      check_status();
      chk("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("arst_rd_data", 32'({bus.rd_err, bus.rd_data}), 32'd0);
      @(negedge clk);
      #1;
      bus.wr_valid = 1'b0;
      rst = 1'b0;

      step(1, 8'h5C, 0, 0, 0, 0);
      step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
